// File: rtl/uart_tx_arbiter.sv
// N-source arbiter for the board TXD pin. Passes the selected TX line through a single
// register and defers a select change until the current source has been idle for a full
// gap, so a character in flight is never cut short. A force input bypasses the idle check.
module uart_tx_arbiter #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned BAUD_PERIOD = 108,
  parameter int unsigned IDLE_BITS   = 11,
  localparam int unsigned SEL_W      = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              sync_reset,
  input  logic [NUM_CH-1:0] tx_in,
  input  logic [SEL_W-1:0]  sel_req,
  input  logic              sel_force,
  output logic              txd,
  output logic [SEL_W-1:0]  sel_active,
  output logic              switch_pending
);

  localparam int unsigned    GAP   = IDLE_BITS * BAUD_PERIOD;
  localparam int unsigned    CNT_W = $clog2(GAP + 1);
  localparam logic [CNT_W-1:0] GapC = CNT_W'(GAP);

  typedef enum logic [0:0] {StPass, StWaitIdle} state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [SEL_W-1:0]   r_sel_active;
  logic [SEL_W-1:0]   w_sel_d;
  logic [CNT_W-1:0]   r_idle_cnt;
  logic [CNT_W-1:0]   w_idle_d;
  logic               r_txd;

  logic               w_req_valid;
  logic               w_req_diff;
  logic               w_switch;
  logic               w_tx_cur;
  logic               w_tx_tgt;
  logic               w_tx_next;

  // Out-of-range requests (possible when NUM_CH is not a power of two) are ignored.
  assign w_req_valid = (32'(sel_req) < NUM_CH);
  assign w_req_diff  = w_req_valid && (sel_req != r_sel_active);

  // Look up the current source and the requested target; unmatched indices read as idle.
  always_comb begin
    w_tx_cur = 1'b1;
    w_tx_tgt = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_sel_active == SEL_W'(i)) w_tx_cur = tx_in[i];
      if (sel_req == SEL_W'(i))      w_tx_tgt = tx_in[i];
    end
  end

  // Select the source value that txd will carry after this edge (uses the new selection).
  always_comb begin
    w_tx_next = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_sel_d == SEL_W'(i)) w_tx_next = tx_in[i];
    end
  end

  // Next-state logic: force beats gap completion; the target is re-sampled every cycle.
  always_comb begin
    w_state_d = r_state;
    w_sel_d   = r_sel_active;
    w_switch  = 1'b0;
    w_idle_d  = r_idle_cnt;

    if (sel_force && w_req_diff) begin
      w_switch = 1'b1;
    end else begin
      case (r_state)
        StPass: begin
          if (w_req_diff) w_state_d = StWaitIdle;
        end
        StWaitIdle: begin
          if (w_req_valid && (sel_req == r_sel_active)) begin
            w_state_d = StPass;
          end else if (w_req_diff && (r_idle_cnt == GapC) && w_tx_tgt) begin
            // Target still mid-frame (low) keeps us waiting.
            w_switch = 1'b1;
          end
        end
        default: w_state_d = StPass;
      endcase
    end

    if (w_switch) begin
      w_sel_d   = sel_req;
      w_state_d = StPass;
    end

    // Idle gap counter runs in both states and restarts on any switch.
    if (w_switch || !w_tx_cur) begin
      w_idle_d = '0;
    end else if (r_idle_cnt != GapC) begin
      w_idle_d = r_idle_cnt + CNT_W'(1);
    end
  end

  // State, selection, idle counter and output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_state      <= StPass;
      r_sel_active <= '0;
      r_idle_cnt   <= '0;
      r_txd        <= 1'b1;
    end else begin
      r_state      <= w_state_d;
      r_sel_active <= w_sel_d;
      r_idle_cnt   <= w_idle_d;
      r_txd        <= w_tx_next;
    end
  end

  assign txd            = r_txd;
  assign sel_active     = r_sel_active;
  assign switch_pending = (r_state == StWaitIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios followed by random traffic, all checked
// against a cycle-level behavioural model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int NCH  = 3;
  localparam int BAUD = 4;
  localparam int IDLE = 2;
  localparam int GAP  = IDLE * BAUD;

  logic       clk = 1'b0;
  logic       sync_reset;
  logic [2:0] tx_in;
  logic [1:0] sel_req;
  logic       sel_force;
  logic       txd;
  logic [1:0] sel_active;
  logic       switch_pending;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_active;
  int m_idle;
  bit m_pending;
  bit m_txd;

  uart_tx_arbiter #(
    .NUM_CH     (NCH),
    .BAUD_PERIOD(BAUD),
    .IDLE_BITS  (IDLE)
  ) dut (
    .clk           (clk),
    .sync_reset    (sync_reset),
    .tx_in         (tx_in),
    .sel_req       (sel_req),
    .sel_force     (sel_force),
    .txd           (txd),
    .sel_active    (sel_active),
    .switch_pending(switch_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock: evaluate the rules on the inputs seen at this edge, then compare.
  task automatic tick();
    int  req;
    bit  valid;
    bit  sw;
    int  nxt_active;
    int  nxt_idle;
    bit  nxt_pending;
    req         = int'(sel_req);
    valid       = (req < NCH);
    sw          = 1'b0;
    nxt_active  = m_active;
    nxt_pending = m_pending;
    if (!sync_reset) begin
      if (sel_force && valid && req != m_active) begin
        sw = 1'b1;
      end else if (m_pending) begin
        if (valid && req == m_active) nxt_pending = 1'b0;
        else if (valid && m_idle == GAP && tx_in[req] == 1'b1) sw = 1'b1;
      end else if (valid && req != m_active) begin
        nxt_pending = 1'b1;
      end
      if (sw) begin
        nxt_active  = req;
        nxt_pending = 1'b0;
      end
      if (sw || tx_in[m_active] == 1'b0) nxt_idle = 0;
      else nxt_idle = (m_idle + 1 > GAP) ? GAP : m_idle + 1;
    end
    @(posedge clk);
    #1;
    if (sync_reset) begin
      m_active  = 0;
      m_idle    = 0;
      m_pending = 1'b0;
      m_txd     = 1'b1;
    end else begin
      m_active  = nxt_active;
      m_idle    = nxt_idle;
      m_pending = nxt_pending;
      m_txd     = tx_in[nxt_active];
    end
    check("model_txd", 32'(txd), 32'(m_txd));
    check("model_sel_active", 32'(sel_active), 32'(m_active));
    check("model_switch_pending", 32'(switch_pending), 32'(m_pending));
  endtask

  initial begin
    logic [7:0] byte_v;
    logic       prev;
    int         edge_at;

    sync_reset = 1'b1;
    tx_in      = 3'b000;
    sel_req    = 2'd0;
    sel_force  = 1'b0;
    m_active   = 0;
    m_idle     = 0;
    m_pending  = 1'b0;
    m_txd      = 1'b1;
    #2;

    // 1: reset holds txd high even with all sources low
    tick();
    tick();
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_sel_active", 32'(sel_active), 32'd0);
    check("reset_pending", 32'(switch_pending), 32'd0);
    sync_reset = 1'b0;
    tick();
    check("release_txd", 32'(txd), 32'd0);

    // 2: pass-through of a 0x55 frame on ch0, one clock of latency
    tx_in  = 3'b111;
    tick();
    byte_v = 8'h55;
    for (int b = 0; b < 10; b++) begin
      tx_in[0] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : byte_v[b-1];
      for (int c = 0; c < BAUD; c++) begin
        prev = tx_in[0];
        tick();
        check("pass_through", 32'(txd), 32'(prev));
      end
    end
    for (int c = 0; c < 12; c++) tick();

    // 3: deferred switch, request arrives mid-frame
    tx_in[0] = 1'b0;
    tick();
    sel_req = 2'd1;
    tick();
    check("deferred_pending", 32'(switch_pending), 32'd1);
    for (int b = 0; b < 8; b++) begin
      tx_in[0] = byte_v[b];
      for (int c = 0; c < BAUD; c++) tick();
    end
    check("deferred_not_yet", 32'(sel_active), 32'd0);
    tx_in[0] = 1'b1;
    edge_at  = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (edge_at == 0 && sel_active == 2'd1) edge_at = k;
    end
    check("deferred_edge", 32'(edge_at), 32'd9);

    // 4: gap expired but target busy, switch waits for target to go high
    tx_in[2] = 1'b0;
    sel_req  = 2'd2;
    tick();
    tx_in[1] = 1'b0;
    for (int c = 0; c < BAUD; c++) tick();
    tx_in[1] = 1'b1;
    for (int c = 0; c < 14; c++) tick();
    check("busy_hold_sel", 32'(sel_active), 32'd1);
    check("busy_hold_pending", 32'(switch_pending), 32'd1);
    tx_in[2] = 1'b1;
    tick();
    check("busy_switch", 32'(sel_active), 32'd2);

    // 5: force mid-frame, then cancel a pending request
    tx_in[2]  = 1'b0;
    tick();
    sel_force = 1'b1;
    sel_req   = 2'd0;
    tick();
    check("force_sel", 32'(sel_active), 32'd0);
    sel_force = 1'b0;
    tx_in     = 3'b110;
    sel_req   = 2'd1;
    tick();
    check("cancel_pending_set", 32'(switch_pending), 32'd1);
    sel_req = 2'd0;
    tick();
    check("cancel_pending_clr", 32'(switch_pending), 32'd0);
    check("cancel_sel", 32'(sel_active), 32'd0);

    // 6: invalid request ignored, reset abandons a pending switch
    tx_in     = 3'b111;
    sel_req   = 2'd3;
    sel_force = 1'b1;
    tick();
    check("invalid_force_sel", 32'(sel_active), 32'd0);
    sel_force = 1'b0;
    tick();
    check("invalid_pending", 32'(switch_pending), 32'd0);
    tx_in[0] = 1'b0;
    sel_req  = 2'd1;
    tick();
    check("pre_reset_pending", 32'(switch_pending), 32'd1);
    sync_reset = 1'b1;
    sel_force  = 1'b1;
    tick();
    check("reset_wait_sel", 32'(sel_active), 32'd0);
    check("reset_wait_pending", 32'(switch_pending), 32'd0);
    sync_reset = 1'b0;
    sel_force  = 1'b0;
    sel_req    = 2'd0;
    tx_in      = 3'b111;
    tick();

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (tx_in[ch] == 1'b1) begin
          if ($urandom_range(0, 19) == 0) tx_in[ch] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          tx_in[ch] = 1'b1;
        end
      end
      if ($urandom_range(0, 39) == 0) sel_req = 2'($urandom_range(0, 3));
      sel_force  = ($urandom_range(0, 149) == 0);
      sync_reset = ($urandom_range(0, 599) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
